box_painter: RTL

BOX_PAINTER -- requirements
Module: box_painter

---
 rtl/box_pkg.sv | 16 +
 rtl/box_scan_counter.sv | 34 +++
 rtl/box_painter.sv | 101 ++++++++++
 3 files changed

// File: rtl/box_pkg.sv
// box_pkg: shared geometry, default colour and FSM encoding for box_painter.
package box_pkg;
    localparam int BOX_SIZE = 32;
    localparam int X_FIRST = 40;
    localparam int X_PITCH = 80;
    localparam int Y_CENTER = 240;
    localparam logic [8:0] DEFAULT_COLOR = 9'b001110000;

    typedef enum logic {IDLE, PAINT} state_t;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest_idx = 3'(i);
    endfunction
endpackage

// File: rtl/box_scan_counter.sv
// box_scan_counter: row-major pixel scan over a BOX_SIZE x BOX_SIZE square.
module box_scan_counter #(
    parameter int BOX_SIZE = box_pkg::BOX_SIZE,
    parameter int CW = $clog2(BOX_SIZE)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          en,
    output logic [CW-1:0] cnt_x,
    output logic [CW-1:0] cnt_y,
    output logic          done
);
    logic [CW-1:0] cnt_x_q, cnt_y_q;
    logic last_x;

    assign last_x = cnt_x_q == CW'(BOX_SIZE - 1);
    assign done = last_x && cnt_y_q == CW'(BOX_SIZE - 1);
    assign cnt_x = cnt_x_q;
    assign cnt_y = cnt_y_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else if (start) begin
            cnt_x_q <= '0;
            cnt_y_q <= '0;
        end else if (en) begin
            cnt_x_q <= last_x ? '0 : cnt_x_q + 1'b1;
            cnt_y_q <= last_x ? cnt_y_q + 1'b1 : cnt_y_q;
        end
    end
endmodule

// File: rtl/box_painter.sv
// box_painter: keeps 8 box colours and repaints any dirty box, lowest index
// first, as a stream of single-pixel writes to a vga_adapter.
module box_painter #(
    parameter int nX = 10,
    parameter int nY = 9,
    parameter int BOX_SIZE = box_pkg::BOX_SIZE,
    parameter int Y_CENTER = box_pkg::Y_CENTER,
    parameter int X_FIRST = box_pkg::X_FIRST,
    parameter int X_PITCH = box_pkg::X_PITCH,
    parameter logic [8:0] DEFAULT_COLOR = box_pkg::DEFAULT_COLOR
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          upd_valid,
    input  logic [2:0]    upd_idx,
    input  logic [8:0]    upd_color,
    output logic [nX-1:0] x,
    output logic [nY-1:0] y,
    output logic [8:0]    color,
    output logic          write,
    output logic          busy
);
    import box_pkg::*;

    localparam int CW = $clog2(BOX_SIZE);
    localparam int X0 = X_FIRST - BOX_SIZE / 2;
    localparam int Y0 = Y_CENTER - BOX_SIZE / 2;

    state_t state_q, state_d;
    logic [8:0] col_q [8];
    logic [7:0] dirty_q, dirty_d;
    logic [2:0] cur_idx_q, cur_idx_d, sel;
    logic [8:0] cur_col_q, cur_col_d, color_q, color_d;
    logic [nX-1:0] x_q, x_d;
    logic [nY-1:0] y_q, y_d;
    logic write_q, write_d, start, done;
    logic [CW-1:0] cnt_x, cnt_y;

    box_scan_counter #(.BOX_SIZE(BOX_SIZE), .CW(CW)) u_scan (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .en(state_q == PAINT),
        .cnt_x(cnt_x),
        .cnt_y(cnt_y),
        .done(done)
    );

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        cur_idx_d = cur_idx_q;
        cur_col_d = cur_col_q;
        start = 1'b0;
        sel = lowest_idx(dirty_q);
        if (state_q == IDLE && |dirty_q) begin
            state_d = PAINT;
            start = 1'b1;
            cur_idx_d = sel;
            cur_col_d = col_q[sel];
            dirty_d[sel] = 1'b0;
        end
        if (state_q == PAINT && done) state_d = IDLE;
        // A fresh update outranks the clear of the box just selected
        if (upd_valid) dirty_d[upd_idx] = 1'b1;
        write_d = state_q == PAINT;
        x_d = write_d ? nX'(X0) + nX'(cur_idx_q) * nX'(X_PITCH) + nX'(cnt_x) : x_q;
        y_d = write_d ? nY'(Y0) + nY'(cnt_y) : y_q;
        color_d = write_d ? cur_col_q : color_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            dirty_q <= 8'hFF;
            col_q <= '{default: DEFAULT_COLOR};
            cur_idx_q <= '0;
            cur_col_q <= '0;
            x_q <= '0;
            y_q <= '0;
            color_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            cur_idx_q <= cur_idx_d;
            cur_col_q <= cur_col_d;
            x_q <= x_d;
            y_q <= y_d;
            color_q <= color_d;
            write_q <= write_d;
            if (upd_valid) col_q[upd_idx] <= upd_color;
        end
    end

    assign x = x_q;
    assign y = y_q;
    assign color = color_q;
    assign write = write_q;
    assign busy = state_q == PAINT || |dirty_q;
endmodule
